// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants, colour widths and a small decode helper
// used by the VGA raster generator and its axis counters.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int CNT_W = 10;
  localparam int R_W   = 3;
  localparam int G_W   = 3;
  localparam int B_W   = 2;

  typedef logic [CNT_W-1:0] coord_t;

  // Inclusive range test on a raster coordinate, done in int so bounds never truncate.
  function automatic logic in_range(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL raster axis counter; wrap flags the enabled cycle that returns to 0,
// so chaining wrap into the next axis's enable builds the x/y raster.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic             clk25,
  input  logic             Reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  assign wrap = enable && (count == coord_t'(TOTAL - 1));

  always_ff @(posedge clk25) begin
    if (Reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (enable) begin
      count <= count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: x/y counters, visible/end-of-frame qualifiers, and a one-stage
// register that blanks game colour and keeps sync aligned with it at the connector.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int   H_FRONT     = vga_pkg::H_FRONT,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BACK      = vga_pkg::H_BACK,
  parameter int   V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int   V_FRONT     = vga_pkg::V_FRONT,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BACK      = vga_pkg::V_BACK,
  parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic             clk25,
  input  logic             Reset,
  input  logic [R_W-1:0]   red_in,
  input  logic [G_W-1:0]   green_in,
  input  logic [B_W-1:0]   blue_in,
  output logic [CNT_W-1:0] xpos,
  output logic [CNT_W-1:0] ypos,
  output logic             visible,
  output logic             end_of_frame,
  output logic             hsync,
  output logic             vsync,
  output logic [R_W-1:0]   red,
  output logic [G_W-1:0]   green,
  output logic [B_W-1:0]   blue
);

  localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START    = H_VISIBLE + H_FRONT;
  localparam int HS_END      = HS_START + H_SYNC - 1;
  localparam int VS_START    = V_VISIBLE + V_FRONT;
  localparam int VS_END      = VS_START + V_SYNC - 1;

  logic line_wrap;
  logic hsync_next;
  logic vsync_next;

  vga_axis_counter #(
    .TOTAL(LINE_TOTAL)
  ) u_hcount (
    .clk25  (clk25),
    .Reset  (Reset),
    .enable (1'b1),
    .count  (xpos),
    .wrap   (line_wrap)
  );

  vga_axis_counter #(
    .TOTAL(FRAME_TOTAL)
  ) u_vcount (
    .clk25  (clk25),
    .Reset  (Reset),
    .enable (line_wrap),
    .count  (ypos),
    .wrap   ()
  );

  assign visible      = (xpos < coord_t'(H_VISIBLE)) && (ypos < coord_t'(V_VISIBLE));
  assign end_of_frame = (xpos == '0) && (ypos == coord_t'(V_VISIBLE));

  assign hsync_next = in_range(xpos, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync_next = in_range(ypos, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // Sync and colour pass through the same register so the connector sees them aligned.
  always_ff @(posedge clk25) begin
    if (Reset) begin
      hsync <= ~SYNC_ACTIVE;
      vsync <= ~SYNC_ACTIVE;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      hsync <= hsync_next;
      vsync <= vsync_next;
      if (visible) begin
        red   <= red_in;
        green <= green_in;
        blue  <= blue_in;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for line-level timing and a
// shrunken-geometry instance (active-high sync) for frame-level behaviour.
module tb_vga_timing_gen;

  logic       clk25 = 1'b0;
  logic       rst;
  logic [2:0] red_in, green_in;
  logic [1:0] blue_in;
  logic [9:0] xpos, ypos;
  logic       visible, eof, hsync, vsync;
  logic [2:0] red, green;
  logic [1:0] blue;

  logic [2:0] s_red_in, s_green_in;
  logic [1:0] s_blue_in;
  logic [9:0] s_xpos, s_ypos;
  logic       s_visible, s_eof, s_hsync, s_vsync;
  logic [2:0] s_red, s_green;
  logic [1:0] s_blue;

  vga_timing_gen dut (
    .clk25(clk25), .Reset(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .xpos(xpos), .ypos(ypos), .visible(visible), .end_of_frame(eof),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
  );

  // 15x13 raster: 8 visible px, sync x=10..12; 6 visible lines, sync y=8..9.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE(1'b1)
  ) dut_small (
    .clk25(clk25), .Reset(rst), .red_in(s_red_in), .green_in(s_green_in), .blue_in(s_blue_in),
    .xpos(s_xpos), .ypos(s_ypos), .visible(s_visible), .end_of_frame(s_eof),
    .hsync(s_hsync), .vsync(s_vsync), .red(s_red), .green(s_green), .blue(s_blue)
  );

  always #20 clk25 = ~clk25;

  int total = 0;
  int bad   = 0;

  int mx, my, mode;
  logic exp_hs, exp_vs;
  logic [2:0] exp_r, exp_g;
  logic [1:0] exp_b;
  int err_pos, err_qual, err_sync, err_rgb;
  int hs_low, hs_first, hs_last, rgb_on, rgb_zero;
  int s_eof_cnt, s_eof_at, s_vs_act, s_hs_act, s_rgb_on, s_vis_cnt;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic applyStimulus(input logic r, input int m);
    rst  = r;
    mode = m;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearStats();
    err_pos = 0; err_qual = 0; err_sync = 0; err_rgb = 0;
    hs_low = 0; hs_first = -1; hs_last = -1; rgb_on = 0; rgb_zero = 0;
  endtask

  // Walks the full-size raster against a reference model, one sample per negedge.
  task automatic runCycles(input int n);
    logic vis_m, eof_m;
    for (int i = 0; i < n; i++) begin
      vis_m = (mx < 640) && (my < 480);
      eof_m = (mx == 0) && (my == 480);
      if (xpos !== 10'(mx) || ypos !== 10'(my)) err_pos++;
      if (visible !== vis_m || eof !== eof_m) err_qual++;
      if (hsync !== exp_hs || vsync !== exp_vs) err_sync++;
      if (red !== exp_r || green !== exp_g || blue !== exp_b) err_rgb++;
      if (hsync === 1'b0) begin
        if (hs_low == 0) hs_first = mx;
        hs_last = mx;
        hs_low++;
      end
      if (red === 3'd7 && green === 3'd7 && blue === 2'd3) rgb_on++;
      if (red === 3'd0 && green === 3'd0 && blue === 2'd0) rgb_zero++;
      if (mode == 0) begin
        red_in = 3'd7; green_in = 3'd7; blue_in = 2'd3;
      end else begin
        red_in = 3'(mx); green_in = 3'(my); blue_in = 2'(mx >> 3);
      end
      exp_hs = (mx >= 656 && mx <= 751) ? 1'b0 : 1'b1;
      exp_vs = (my >= 490 && my <= 491) ? 1'b0 : 1'b1;
      if (vis_m) begin
        exp_r = red_in; exp_g = green_in; exp_b = blue_in;
      end else begin
        exp_r = 3'd0; exp_g = 3'd0; exp_b = 2'd0;
      end
      if (mx == 799) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      cyc(1);
    end
  endtask

  initial begin
    red_in = 3'd0; green_in = 3'd0; blue_in = 2'd0;
    s_red_in = 3'd7; s_green_in = 3'd7; s_blue_in = 2'd3;
    applyStimulus(1'b1, 0);
    cyc(2);

    checkOutput("rst_xpos", xpos, 0);
    checkOutput("rst_ypos", ypos, 0);
    checkOutput("rst_rgb", {red, green, blue}, 0);
    checkOutput("rst_hsync", hsync, 1);
    checkOutput("rst_vsync", vsync, 1);
    checkOutput("rst_eof", eof, 0);
    checkOutput("rst_small_hsync", s_hsync, 0);

    // Line 0 with constant colour: blanking, hsync placement, x wrap.
    mx = 0; my = 0; exp_hs = 1'b1; exp_vs = 1'b1;
    exp_r = 3'd0; exp_g = 3'd0; exp_b = 2'd0;
    clearStats();
    applyStimulus(1'b0, 0);
    runCycles(800);
    checkOutput("xwrap_xpos", xpos, 0);
    checkOutput("xwrap_ypos", ypos, 1);
    checkOutput("line_hs_low_count", hs_low, 96);
    checkOutput("line_hs_first_x", hs_first, 657);
    checkOutput("line_hs_last_x", hs_last, 752);
    checkOutput("line_rgb_on_count", rgb_on, 640);
    checkOutput("line_rgb_zero_count", rgb_zero, 160);
    checkOutput("line_pos_errs", err_pos, 0);
    checkOutput("line_qual_errs", err_qual, 0);
    checkOutput("line_sync_errs", err_sync, 0);
    checkOutput("line_rgb_errs", err_rgb, 0);

    // Lines 1-2 with coordinate-derived colour: one-cycle latency and blanking.
    clearStats();
    applyStimulus(1'b0, 1);
    runCycles(1600);
    checkOutput("pat_latency_errs", err_rgb, 0);
    checkOutput("pat_pos_errs", err_pos, 0);
    checkOutput("pat_sync_errs", err_sync, 0);
    checkOutput("pat_hs_low_count", hs_low, 192);

    runCycles(300);
    checkOutput("mid_xpos", xpos, 300);
    checkOutput("mid_ypos", ypos, 3);
    checkOutput("mid_red_nonzero", red, 3);

    // Mid-frame reset held for two edges.
    applyStimulus(1'b1, 1);
    cyc(1);
    checkOutput("midrst_prio_xpos", xpos, 0);
    cyc(1);
    checkOutput("midrst_xpos", xpos, 0);
    checkOutput("midrst_ypos", ypos, 0);
    checkOutput("midrst_rgb", {red, green, blue}, 0);
    checkOutput("midrst_hsync", hsync, 1);
    checkOutput("midrst_vsync", vsync, 1);
    checkOutput("midrst_small_vsync", s_vsync, 0);

    // One full small frame from release: frame wrap, end_of_frame, vsync, visible area.
    s_eof_cnt = 0; s_eof_at = -1; s_vs_act = 0; s_hs_act = 0; s_rgb_on = 0; s_vis_cnt = 0;
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 195; i++) begin
      if (i == 1) begin
        checkOutput("release_xpos", xpos, 1);
        checkOutput("release_ypos", ypos, 0);
      end
      if (i == 15) begin
        checkOutput("small_ywrap_xpos", s_xpos, 0);
        checkOutput("small_ywrap_ypos", s_ypos, 1);
      end
      if (s_eof === 1'b1) begin
        s_eof_cnt++;
        s_eof_at = i;
      end
      if (s_visible === 1'b1) s_vis_cnt++;
      if (s_vsync === 1'b1) s_vs_act++;
      if (s_hsync === 1'b1) s_hs_act++;
      if (s_red === 3'd7 && s_green === 3'd7 && s_blue === 2'd3) s_rgb_on++;
      cyc(1);
    end
    checkOutput("small_frame_xpos", s_xpos, 0);
    checkOutput("small_frame_ypos", s_ypos, 0);
    checkOutput("small_eof_count", s_eof_cnt, 1);
    checkOutput("small_eof_cycle", s_eof_at, 90);
    checkOutput("small_visible_count", s_vis_cnt, 48);
    checkOutput("small_vsync_count", s_vs_act, 30);
    checkOutput("small_hsync_count", s_hs_act, 39);
    checkOutput("small_rgb_on_count", s_rgb_on, 48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
